// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit.
// One operation is in flight at a time. Multiplies use iterative shift-add and
// divides use restoring division, one step per cycle, on operand magnitudes.
// The result sign is applied on the final step. Divide-by-zero and signed
// overflow finish in one cycle, and so do multiplies when FAST_MUL=1.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] acc;       // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   dvsr;      // multiplicand or divisor magnitude
  logic [2:0]        op_q;
  logic              neg_main;  // negate product / quotient
  logic              neg_rem;   // negate remainder (sign of dividend)

  logic              accept, in_special, in_fast, in_quick, sa_in, sb_in;
  logic [XLEN-1:0]   quick_res, quo, rem, fin_res;
  logic [2*XLEN-1:0] acc_step, prod;

  function automatic logic a_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] special_div(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : a;
  endfunction

  function automatic logic [XLEN-1:0] fast_mul(input logic [2:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] ea, eb, p;
    ea = a_signed(op) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = b_signed(op) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ea * eb;
    return (op == 3'b000) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] a,
                                                  input logic [XLEN-1:0] m);
    logic [XLEN:0] addend, sum;
    addend = a[0] ? {1'b0, m} : '0;
    sum    = {1'b0, a[2*XLEN-1:XLEN]} + addend;
    return {sum, a[XLEN-1:1]};
  endfunction

  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] a,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN:0] rsh, diff;
    rsh  = a[2*XLEN-1:XLEN-1];
    diff = rsh - {1'b0, d};
    if (!diff[XLEN]) return {diff[XLEN-1:0], a[XLEN-2:0], 1'b1};
    return {rsh[XLEN-1:0], a[XLEN-2:0], 1'b0};
  endfunction

  assign accept     = in_valid && in_ready && !flush;
  assign in_special = in_op[2] && ((in_b == '0) ||
                      (!in_op[0] && (in_a == MIN_NEG) && (in_b == '1)));
  assign in_fast    = (FAST_MUL != 0) && !in_op[2];
  assign in_quick   = in_special || in_fast;
  assign quick_res  = in_special ? special_div(in_op, in_a, in_b) : fast_mul(in_op, in_a, in_b);
  assign sa_in      = a_signed(in_op) && in_a[XLEN-1];
  assign sb_in      = b_signed(in_op) && in_b[XLEN-1];

  assign acc_step = op_q[2] ? div_step(acc, dvsr) : mul_step(acc, dvsr);
  assign prod     = cond_neg_w(acc_step, neg_main);
  assign quo      = cond_neg(acc_step[XLEN-1:0], neg_main);
  assign rem      = cond_neg(acc_step[2*XLEN-1:XLEN], neg_rem);
  assign fin_res  = op_q[2] ? (op_q[1] ? rem : quo)
                            : ((op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign out_zero = (out_result == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush wins over accept and out_ready
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = in_quick ? S_DONE : S_CALC;
        S_CALC:  if (counter == '0) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Step counter: XLEN steps, counting XLEN-1 down to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             counter <= '0;
    else if (flush)                      counter <= '0;
    else if (accept && !in_quick)        counter <= CNT_INIT;
    else if (state == S_CALC && counter != '0) counter <= counter - CW'(1);
  end

  // Operand magnitudes latched on accept, then one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      acc      <= {{XLEN{1'b0}}, cond_neg(in_a, sa_in)};
      dvsr     <= cond_neg(in_b, sb_in);
      op_q     <= in_op;
      neg_main <= sa_in ^ sb_in;
      neg_rem  <= sa_in;
    end else if (state == S_CALC) begin
      acc <= acc_step;
    end
  end

  // Result and tag registers, held stable through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
      if (in_quick) out_result <= quick_res;
    end else if (state == S_CALC && counter == '0 && !flush) begin
      out_result <= fin_res;
    end
  end

endmodule
